fetch_ctrl: RTL



---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_ctrl_if.sv | 24 ++
 rtl/fetch_skid.sv | 33 +++
 rtl/fetch_ctrl.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction-fetch control stage.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response channel between fetch_ctrl (master) and memory (slave).
// Request: a transfer happens on a clk edge where imem_req_valid && imem_req_ready; once valid is
// raised the address is held until that handshake. Response: imem_rsp_valid is a one-cycle pulse
// with no backpressure, so the master must always be able to accept or discard it.
interface fetch_ctrl_if #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
) ();
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data
  );
endinterface

// File: rtl/fetch_skid.sv
// One-entry holding buffer for a response that arrives while the IF/ID output is stalled.
import fetch_pkg::*;

module fetch_skid (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         unload,
  input  logic         clear,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic         full
);

  fetch_entry_t entry_q;
  logic         full_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      full_q  <= 1'b0;
      entry_q <= '{instr: NOP_INSTR, pc: '0};
    end else if (load) begin
      full_q  <= 1'b1;
      entry_q <= din;
    end else if (unload) begin
      full_q  <= 1'b0;
    end
  end

  assign dout = entry_q;
  assign full = full_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch control: one outstanding imem request, output register plus skid for stalls.
// Optional macro FETCH_PERF_CNT_EN adds fetch_wait_cnt (cycles spent in WAIT/DROP, saturating).
import fetch_pkg::*;

module fetch_ctrl #(
  parameter int              XLEN      = fetch_pkg::XLEN,
  parameter int              ILEN      = fetch_pkg::ILEN,
  parameter logic [ILEN-1:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [XLEN-1:0]     pc_f,
  output logic                pc_en,
  input  logic                redirect,
  input  logic                stall_in,
  fetch_ctrl_if.master        imem,
  output logic [ILEN-1:0]     instr_f,
  output logic [XLEN-1:0]     pc_out_f,
  output logic                instr_valid_f,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]         fetch_wait_cnt,
`endif
  output fetch_state_t        state_dbg
);

  fetch_state_t    state, state_n;
  logic [XLEN-1:0] req_pc;
  logic            hs, rsp_to_out, rsp_to_skid, skid_to_out;
  fetch_entry_t    skid_dout;
  logic            skid_full;

  always_ff @(posedge clk) begin
    if (rst) state <= REQ;
    else     state <= state_n;
  end

  always_comb begin
    state_n     = state;
    hs          = 1'b0;
    rsp_to_out  = 1'b0;
    rsp_to_skid = 1'b0;
    skid_to_out = 1'b0;
    case (state)
      REQ: begin
        if (imem.imem_req_ready) begin
          hs      = 1'b1;
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (imem.imem_rsp_valid) begin
          if (!instr_valid_f || !stall_in) begin
            rsp_to_out = 1'b1;
            state_n    = REQ;
          end else begin
            rsp_to_skid = 1'b1;
            state_n     = HOLD;
          end
        end
      end
      HOLD: begin
        if (!stall_in) begin
          skid_to_out = 1'b1;
          state_n     = REQ;
        end
      end
      DROP: begin
        if (imem.imem_rsp_valid) state_n = REQ;
      end
      default: state_n = REQ;
    endcase
    // A redirect squashes any delivery; a request still in flight must be drained in DROP.
    // In DROP, a response arriving in the redirect cycle is the one being drained, so REQ follows.
    if (redirect) begin
      rsp_to_out  = 1'b0;
      rsp_to_skid = 1'b0;
      skid_to_out = 1'b0;
      if (hs || ((state == WAIT || state == DROP) && !imem.imem_rsp_valid)) state_n = DROP;
      else                                                                    state_n = REQ;
    end
  end

  assign pc_en               = hs || redirect;
  assign imem.imem_req_valid = (state == REQ);
  assign imem.imem_req_addr  = pc_f;
  assign state_dbg           = state;

  always_ff @(posedge clk) begin
    if (rst)     req_pc <= '0;
    else if (hs) req_pc <= pc_f;
  end

  fetch_skid u_skid (
    .clk    (clk),
    .rst    (rst),
    .load   (rsp_to_skid),
    .unload (skid_to_out),
    .clear  (redirect),
    .din    ('{instr: imem.imem_rsp_data, pc: req_pc}),
    .dout   (skid_dout),
    .full   (skid_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_valid_f <= 1'b0;
      instr_f       <= NOP_INSTR;
      pc_out_f      <= '0;
    end else if (redirect) begin
      instr_valid_f <= 1'b0;
      instr_f       <= NOP_INSTR;
    end else if (rsp_to_out) begin
      instr_valid_f <= 1'b1;
      instr_f       <= imem.imem_rsp_data;
      pc_out_f      <= req_pc;
    end else if (skid_to_out) begin
      instr_valid_f <= 1'b1;
      instr_f       <= skid_dout.instr;
      pc_out_f      <= skid_dout.pc;
    end else if (instr_valid_f && !stall_in) begin
      instr_valid_f <= 1'b0;
      instr_f       <= NOP_INSTR;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      fetch_wait_cnt <= '0;
    else if ((state == WAIT || state == DROP) && fetch_wait_cnt != 32'hFFFF_FFFF)
      fetch_wait_cnt <= fetch_wait_cnt + 32'd1;
  end
`endif

  // Responses are only legal while a request is outstanding; HOLD always has a full skid.
  a_rsp_legal: assert property (@(posedge clk) disable iff (rst)
    !(imem.imem_rsp_valid && (state == REQ || state == HOLD)));
  a_hold_full: assert property (@(posedge clk) disable iff (rst)
    (state == HOLD) |-> skid_full);

endmodule
